// File: rtl/sam_pkg.sv
// sam_pkg: types and constants shared by the SAM transmitter and receiver.
package sam_pkg;

  localparam int SAM_KEY_W = 32;
  localparam int SAM_N_W   = 4;
  localparam int SAM_N_MAX = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_N,
    S_CFG_KEY,
    S_CFG_MASK,
    S_DATA_WAIT,
    S_SYMBOL
  } sam_tx_state_t;

  // Key length L = 2^n. The result is 7 bits wide so that n=5 (L=32) fits.
  function automatic logic [6:0] sam_key_len(input logic [SAM_N_W-1:0] n);
    return 7'd1 << n;
  endfunction

endpackage

// File: rtl/sam_tx_if.sv
// sam_tx_if: configuration, plaintext handshake and serial line of sam_tx.
interface sam_tx_if;
  import sam_pkg::*;

  logic                 cfg_start;
  logic [SAM_N_W-1:0]   cfg_n;
  logic [SAM_KEY_W-1:0] cfg_key;
  logic [SAM_KEY_W-1:0] cfg_mask;
  logic                 data_valid;
  logic                 data_bit;
  logic                 data_ready;
  logic                 str;
  logic                 mode;
  logic                 busy;

  modport master (
    output cfg_start, cfg_n, cfg_key, cfg_mask, data_valid, data_bit,
    input  data_ready, str, mode, busy
  );

  modport slave (
    input  cfg_start, cfg_n, cfg_key, cfg_mask, data_valid, data_bit,
    output data_ready, str, mode, busy
  );
endinterface

// File: rtl/sam_symbol_gen.sv
// sam_symbol_gen: shapes one duty-cycle symbol of PERIOD clocks.
// c=1 -> high for PERIOD-1 cycles, c=0 -> high for the first cycle only;
// the last cycle is always low. 'last' flags cycle PERIOD-1.
module sam_symbol_gen #(
  parameter int PERIOD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic c,
  output logic line,
  output logic last
);

  logic [5:0] r_cnt;
  logic       r_c;
  logic       r_line;
  logic       r_last;

  // Down-counter runs PERIOD-1..0; line/last are precomputed for the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_c    <= 1'b0;
      r_line <= 1'b0;
      r_last <= 1'b0;
    end else if (start) begin
      r_cnt  <= 6'(PERIOD - 1);
      r_c    <= c;
      r_line <= 1'b1;
      r_last <= 1'b0;
    end else if (r_cnt != 6'd0) begin
      r_cnt  <= r_cnt - 6'd1;
      r_line <= r_c && (r_cnt != 6'd1);
      r_last <= (r_cnt == 6'd1);
    end else begin
      r_line <= 1'b0;
      r_last <= 1'b0;
    end
  end

  assign line = r_line;
  assign last = r_last;

endmodule

// File: rtl/sam_tx.sv
// sam_tx: SAM link transmitter. Sends the n/key/mask configuration frame,
// then one duty-cycle symbol per accepted plaintext bit.
// Optional macro SAM_TX_ENCRYPT_EN: when defined c = p ^ key[k], otherwise c = p
// (key still sent and k still advances, so timing does not change).
//
// state       | meaning
// ------------+------------------------------------------
// S_IDLE      | unconfigured, data ignored
// S_CFG_N     | sending n[3..0]
// S_CFG_KEY   | sending key[L-1..0]
// S_CFG_MASK  | sending mask[L-1..0]
// S_DATA_WAIT | configured, waiting for a plaintext bit
// S_SYMBOL    | sending one ciphertext symbol
module sam_tx
  import sam_pkg::*;
#(
  parameter int PERIOD = 8,
  parameter int N_MAX  = SAM_N_MAX
) (
  input  logic     clk,
  input  logic     reset,
  sam_tx_if.slave  bus
);

  sam_tx_state_t        r_state, w_state_nxt;
  logic [SAM_N_W-1:0]   r_n, w_n_clamp;
  logic [SAM_KEY_W-1:0] r_key, r_mask;
  logic [4:0]           r_cnt, r_k, w_cm1, w_lm1, w_lm1_new;
  logic [6:0]           w_len, w_len_new;
  logic                 r_cfg_str, r_mode, r_busy;
  logic                 w_cfg_go, w_hs, w_ready, w_c, w_line, w_last, w_cfg_nxt;

  assign w_n_clamp = (bus.cfg_n > 4'(N_MAX)) ? 4'(N_MAX) : bus.cfg_n;
  assign w_len     = sam_key_len(r_n);
  assign w_len_new = sam_key_len(w_n_clamp);
  assign w_lm1     = 5'(w_len - 7'd1);
  assign w_lm1_new = 5'(w_len_new - 7'd1);
  assign w_cm1     = r_cnt - 5'd1;

  // cfg_start only counts in IDLE/DATA_WAIT and beats a simultaneous data_valid.
  assign w_cfg_go = bus.cfg_start && (r_state == S_IDLE || r_state == S_DATA_WAIT);
  assign w_ready  = (r_state == S_DATA_WAIT) || (r_state == S_SYMBOL && w_last);
  assign w_hs     = bus.data_valid && w_ready && !w_cfg_go;

`ifdef SAM_TX_ENCRYPT_EN
  assign w_c = bus.data_bit ^ r_key[r_k];
`else
  assign w_c = bus.data_bit;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; r_cnt holds the index of the bit currently on the line.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (bus.cfg_start) w_state_nxt = S_CFG_N;
      S_CFG_N:     if (r_cnt == 5'd0) w_state_nxt = S_CFG_KEY;
      S_CFG_KEY:   if (r_cnt == 5'd0) w_state_nxt = S_CFG_MASK;
      S_CFG_MASK:  if (r_cnt == 5'd0) w_state_nxt = S_DATA_WAIT;
      S_DATA_WAIT: begin
        if (bus.cfg_start) w_state_nxt = S_CFG_N;
        else if (w_hs)     w_state_nxt = S_SYMBOL;
      end
      S_SYMBOL:    if (w_last && !w_hs) w_state_nxt = S_DATA_WAIT;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  assign w_cfg_nxt = (w_state_nxt == S_CFG_N) || (w_state_nxt == S_CFG_KEY) ||
                     (w_state_nxt == S_CFG_MASK);

  // Config latches, frame bit serializer, key index and registered mode/busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n       <= '0;
      r_key     <= '0;
      r_mask    <= '0;
      r_cnt     <= '0;
      r_k       <= '0;
      r_cfg_str <= 1'b0;
      r_mode    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_mode <= w_cfg_nxt;
      r_busy <= w_cfg_nxt || (w_state_nxt == S_SYMBOL);
      if (w_cfg_go) begin
        r_n       <= w_n_clamp;
        r_key     <= bus.cfg_key;
        r_mask    <= bus.cfg_mask;
        r_k       <= w_lm1_new;
        r_cnt     <= 5'd3;
        r_cfg_str <= w_n_clamp[3];
      end else begin
        if (w_hs) r_k <= (r_k == 5'd0) ? w_lm1 : r_k - 5'd1;
        case (r_state)
          S_CFG_N: begin
            if (r_cnt == 5'd0) begin
              r_cnt     <= w_lm1;
              r_cfg_str <= r_key[w_lm1];
            end else begin
              r_cnt     <= w_cm1;
              r_cfg_str <= r_n[w_cm1[1:0]];
            end
          end
          S_CFG_KEY: begin
            if (r_cnt == 5'd0) begin
              r_cnt     <= w_lm1;
              r_cfg_str <= r_mask[w_lm1];
            end else begin
              r_cnt     <= w_cm1;
              r_cfg_str <= r_key[w_cm1];
            end
          end
          S_CFG_MASK: begin
            if (r_cnt == 5'd0) begin
              r_cfg_str <= 1'b0;
            end else begin
              r_cnt     <= w_cm1;
              r_cfg_str <= r_mask[w_cm1];
            end
          end
          default: r_cfg_str <= 1'b0;
        endcase
      end
    end
  end

  sam_symbol_gen #(.PERIOD(PERIOD)) u_sym (
    .clk   (clk),
    .reset (reset),
    .start (w_hs),
    .c     (w_c),
    .line  (w_line),
    .last  (w_last)
  );

  // Both sources are registers and are never high at the same time.
  assign bus.str        = r_cfg_str | w_line;
  assign bus.mode       = r_mode;
  assign bus.busy       = r_busy;
  assign bus.data_ready = w_ready;

endmodule

// File: tb/tb_sam_tx.sv
// tb_sam_tx: directed bench for sam_tx (PERIOD=8, N_MAX=5).
module tb_sam_tx;
  import sam_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  sam_tx_if bus ();

  sam_tx #(.PERIOD(8), .N_MAX(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records str while mode is high; bounded so a stuck frame cannot hang the run.
  task automatic run_frame(output int cnt, output logic [127:0] bits);
    cnt  = 0;
    bits = '0;
    while (bus.mode === 1'b1 && cnt < 200) begin
      bits = {bits[126:0], bus.str};
      cnt++;
      tick();
    end
  endtask

  function automatic logic [7:0] sym(input logic c);
    return c ? 8'hFE : 8'h80;
  endfunction

  initial begin
    int           cnt;
    logic [127:0] bits;
    logic [39:0]  stream;
    logic [4:0]   exp_enc;
    logic [1:0]   exp_f;
    logic         exp_prio;
    logic         exp_c3;

`ifdef SAM_TX_ENCRYPT_EN
    exp_enc  = 5'b01010;
    exp_f    = 2'b01;
    exp_prio = 1'b0;
    exp_c3   = 1'b1;
`else
    exp_enc  = 5'b11111;
    exp_f    = 2'b10;
    exp_prio = 1'b1;
    exp_c3   = 1'b0;
`endif

    reset          = 1'b0;
    bus.cfg_start  = 1'b0;
    bus.cfg_n      = '0;
    bus.cfg_key    = '0;
    bus.cfg_mask   = '0;
    bus.data_valid = 1'b0;
    bus.data_bit   = 1'b0;
    tick();
    tick();
    chk("rst_str", bus.str, 1'b0);
    chk("rst_mode", bus.mode, 1'b0);
    chk("rst_ready", bus.data_ready, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    reset = 1'b1;
    tick();

    // Data offered before any configuration is ignored.
    bus.data_valid = 1'b1;
    bus.data_bit   = 1'b1;
    tick();
    tick();
    chk("idle_ready", bus.data_ready, 1'b0);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_str", bus.str, 1'b0);
    bus.data_valid = 1'b0;

    // Config frame n=2, key=A, mask=3.
    bus.cfg_start = 1'b1;
    bus.cfg_n     = 4'd2;
    bus.cfg_key   = 32'h0000_000A;
    bus.cfg_mask  = 32'h0000_0003;
    tick();
    bus.cfg_start = 1'b0;
    chk("cfg_busy", bus.busy, 1'b1);
    run_frame(cnt, bits);
    chk("cfg_len", cnt, 12);
    chk("cfg_bits", bits[11:0], 12'b0010_1010_0011);
    chk("cfg_end_str", bus.str, 1'b0);
    chk("cfg_end_ready", bus.data_ready, 1'b1);
    chk("cfg_end_busy", bus.busy, 1'b0);

    // Five back-to-back plaintext 1s; fifth symbol uses wrapped key index.
    bus.data_valid = 1'b1;
    bus.data_bit   = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      stream = {stream[38:0], bus.str};
      if (i == 3) chk("sym_mid_ready", bus.data_ready, 1'b0);
      if (i == 7) chk("sym_last_ready", bus.data_ready, 1'b1);
      if (i == 20) chk("sym_busy", bus.busy, 1'b1);
      if (i == 33) bus.data_valid = 1'b0;
      tick();
    end
    chk("enc_sym0", stream[39:32], sym(exp_enc[4]));
    chk("enc_sym1", stream[31:24], sym(exp_enc[3]));
    chk("enc_sym2", stream[23:16], sym(exp_enc[2]));
    chk("enc_sym3", stream[15:8],  sym(exp_enc[1]));
    chk("enc_sym4", stream[7:0],   sym(exp_enc[0]));
    chk("enc_done_busy", bus.busy, 1'b0);
    chk("enc_done_ready", bus.data_ready, 1'b1);
    chk("enc_done_str", bus.str, 1'b0);

    // cfg_start and data_valid together: new frame wins, k reloads to L-1.
    bus.cfg_start  = 1'b1;
    bus.data_valid = 1'b1;
    tick();
    bus.cfg_start  = 1'b0;
    bus.data_valid = 1'b0;
    chk("prio_mode", bus.mode, 1'b1);
    chk("prio_ready", bus.data_ready, 1'b0);
    run_frame(cnt, bits);
    chk("prio_len", cnt, 12);
    bus.data_valid = 1'b1;
    bus.data_bit   = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      stream = {stream[38:0], bus.str};
      tick();
    end
    chk("prio_sym", stream[7:0], sym(exp_prio));

    // key=F, plaintext 1 then 0 back-to-back.
    bus.cfg_start = 1'b1;
    bus.cfg_key   = 32'h0000_000F;
    tick();
    bus.cfg_start = 1'b0;
    run_frame(cnt, bits);
    chk("keyf_bits", bits[11:0], 12'b0010_1111_0011);
    bus.data_valid = 1'b1;
    bus.data_bit   = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      stream = {stream[38:0], bus.str};
      if (i == 1) bus.data_bit = 1'b0;
      if (i == 9) bus.data_valid = 1'b0;
      tick();
    end
    chk("keyf_sym0", stream[15:8], sym(exp_f[1]));
    chk("keyf_sym1", stream[7:0],  sym(exp_f[0]));

    // cfg_start during a symbol is ignored and not queued.
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    bus.cfg_start  = 1'b1;
    tick();
    bus.cfg_start  = 1'b0;
    chk("symcfg_mode", bus.mode, 1'b0);
    chk("symcfg_busy", bus.busy, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    chk("symcfg_after_mode", bus.mode, 1'b0);
    chk("symcfg_after_ready", bus.data_ready, 1'b1);

    // n clamp and full 32-bit key/mask.
    bus.cfg_start = 1'b1;
    bus.cfg_n     = 4'd15;
    bus.cfg_key   = 32'h8000_0001;
    bus.cfg_mask  = 32'hFFFF_0000;
    tick();
    bus.cfg_start = 1'b0;
    run_frame(cnt, bits);
    chk("clamp_len", cnt, 68);
    chk("clamp_n", bits[67:64], 4'b0101);
    chk("clamp_key", bits[63:32], 32'h8000_0001);
    chk("clamp_mask", bits[31:0], 32'hFFFF_0000);

    // Reset in cycle 3 of a symbol aborts asynchronously.
    bus.data_valid = 1'b1;
    bus.data_bit   = 1'b0;
    tick();
    bus.data_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_pre_busy", bus.busy, 1'b1);
    chk("abort_pre_str", bus.str, exp_c3);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_str", bus.str, 1'b0);
    chk("abort_mode", bus.mode, 1'b0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_ready", bus.data_ready, 1'b0);
    #2;
    reset = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_bit   = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_busy", bus.busy, 1'b0);
    chk("post_rst_ready", bus.data_ready, 1'b0);
    chk("post_rst_str", bus.str, 1'b0);
    bus.data_valid = 1'b0;

    // Minimum key length n=0 (L=1): 6-cycle frame.
    bus.cfg_start = 1'b1;
    bus.cfg_n     = 4'd0;
    bus.cfg_key   = 32'h0000_0001;
    bus.cfg_mask  = 32'h0000_0000;
    tick();
    bus.cfg_start = 1'b0;
    run_frame(cnt, bits);
    chk("n0_len", cnt, 6);
    chk("n0_bits", bits[5:0], 6'b0000_10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
